// File: rtl/divisor_4b.sv
// divisor_4b: interactive 4-bit unsigned divider behind three push buttons.
//
// The user steps a numerator and then a denominator up/down, confirming each
// with ok. The block then shows the quotient, and after the next ok the
// remainder. One more ok clears everything and returns to numerator entry.
//
// Ports:
//   clk   system clock, all state changes on the rising edge
//   rst   asynchronous active-low reset
//   down  decrement button (active-high, synchronous to clk)
//   up    increment button (active-high, synchronous to clk)
//   ok    confirm/advance button (active-high, synchronous to clk)
//   leds  displayed value, unsigned binary, bit 3 = MSB

// One restoring-division step: shift in the next numerator bit and subtract
// the divisor when it fits.
module divisor_4b_stage (
    input  logic [3:0] prev_part,
    input  logic       nbit,
    input  logic [3:0] den,
    output logic       qbit,
    output logic [3:0] next_part
);
    logic [4:0] shifted;

    assign shifted   = {prev_part, nbit};
    assign qbit      = (shifted >= {1'b0, den});
    // When qbit is set the difference is below den, so 4 bits hold it
    // exactly; the subtraction wraps harmlessly in the high bit.
    assign next_part = qbit ? (shifted[3:0] - den) : shifted[3:0];
endmodule

module divisor_4b (
    input  logic       clk,
    input  logic       rst,
    input  logic       down,
    input  logic       up,
    input  logic       ok,
    output logic [3:0] leds
);
    typedef enum logic [1:0] {
        LOAD_NUM,
        LOAD_DEN,
        SHOW_Q,
        SHOW_R
    } state_t;

    state_t     state, state_nxt;
    logic       prev_up, prev_down, prev_ok;
    logic       up_p, down_p, ok_p;
    logic       inc, dec;
    logic [3:0] num, den, quo, rem;
    logic [3:0] num_nxt, den_nxt, quo_nxt, rem_nxt;
    logic [3:0] div_q, div_r;

    // Partial remainders between the unrolled stages; part[4] is the seed.
    logic [3:0] part [0:4];

    // A press is the first cycle a button is seen high.
    assign up_p   = up   & ~prev_up;
    assign down_p = down & ~prev_down;
    assign ok_p   = ok   & ~prev_ok;

    // up and down together cancel; ok is handled first in the FSM, so it
    // overrides both.
    assign inc = up_p & ~down_p;
    assign dec = down_p & ~up_p;

    // Combinational divider, MSB stage first. A zero divisor makes every
    // stage "fit", which naturally yields quo=4'hF and rem=num.
    assign part[4] = 4'd0;
    for (genvar i = 0; i < 4; i++) begin : g_stage
        divisor_4b_stage u_stage (
            .prev_part (part[i+1]),
            .nbit      (num[i]),
            .den       (den),
            .qbit      (div_q[i]),
            .next_part (part[i])
        );
    end
    assign div_r = part[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= LOAD_NUM;
            prev_up   <= 1'b0;
            prev_down <= 1'b0;
            prev_ok   <= 1'b0;
            num       <= 4'd0;
            den       <= 4'd0;
            quo       <= 4'd0;
            rem       <= 4'd0;
        end else begin
            state     <= state_nxt;
            prev_up   <= up;
            prev_down <= down;
            prev_ok   <= ok;
            num       <= num_nxt;
            den       <= den_nxt;
            quo       <= quo_nxt;
            rem       <= rem_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        num_nxt   = num;
        den_nxt   = den;
        quo_nxt   = quo;
        rem_nxt   = rem;
        case (state)
            LOAD_NUM: begin
                if (ok_p)     state_nxt = LOAD_DEN;
                else if (inc) num_nxt   = num + 4'd1;
                else if (dec) num_nxt   = num - 4'd1;
            end
            LOAD_DEN: begin
                if (ok_p) begin
                    quo_nxt   = div_q;
                    rem_nxt   = div_r;
                    state_nxt = SHOW_Q;
                end
                else if (inc) den_nxt = den + 4'd1;
                else if (dec) den_nxt = den - 4'd1;
            end
            SHOW_Q: begin
                if (ok_p) state_nxt = SHOW_R;
            end
            SHOW_R: begin
                if (ok_p) begin
                    num_nxt   = 4'd0;
                    den_nxt   = 4'd0;
                    quo_nxt   = 4'd0;
                    rem_nxt   = 4'd0;
                    state_nxt = LOAD_NUM;
                end
            end
            default: state_nxt = LOAD_NUM;
        endcase
    end

    // Display mux straight off registers, so reset blanks it immediately.
    always_comb begin
        leds = 4'd0;
        case (state)
            LOAD_NUM: leds = num;
            LOAD_DEN: leds = den;
            SHOW_Q:   leds = quo;
            SHOW_R:   leds = rem;
            default:  leds = 4'd0;
        endcase
    end
endmodule

// File: tb/tb_divisor_4b.sv
module tb_divisor_4b;
    logic       clk;
    logic       rst;
    logic       down, up, ok;
    logic [3:0] leds;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [3:0] exp;
    } sb_entry_t;

    sb_entry_t sb[$];

    divisor_4b dut (
        .clk  (clk),
        .rst  (rst),
        .down (down),
        .up   (up),
        .ok   (ok),
        .leds (leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: leds=%0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic void push(input string name, input logic [3:0] exp);
        sb_entry_t e;
        e.name = name;
        e.exp  = exp;
        sb.push_back(e);
    endfunction

    // Monitor: leds is stable away from the rising edge, so compare on the
    // falling edge whenever an expectation is pending.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            sb_entry_t e;
            e = sb.pop_front();
            check(e.name, leds, e.exp);
        end
    end

    // One-cycle button pulse followed by at least one idle cycle.
    task automatic pulse(input logic u, input logic d, input logic o,
                         input string name, input logic [3:0] exp);
        @(negedge clk);
        up = u; down = d; ok = o;
        @(posedge clk);
        #1 push(name, exp);
        @(negedge clk);
        up = 1'b0; down = 1'b0; ok = 1'b0;
    endtask

    task automatic press_up(input string name, input logic [3:0] exp);
        pulse(1'b1, 1'b0, 1'b0, name, exp);
    endtask

    task automatic press_dn(input string name, input logic [3:0] exp);
        pulse(1'b0, 1'b1, 1'b0, name, exp);
    endtask

    task automatic press_ok(input string name, input logic [3:0] exp);
        pulse(1'b0, 1'b0, 1'b1, name, exp);
    endtask

    initial begin
        int t;
        rst = 1'b1; up = 1'b0; down = 1'b0; ok = 1'b0;
        #2 rst = 1'b0;
        #1 check("reset_async", leds, 4'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 push("after_reset", 4'd0);
        @(negedge clk);

        // Numerator entry and hold behaviour
        press_up("num_1", 4'd1);
        press_up("num_2", 4'd2);
        press_up("num_3", 4'd3);
        press_up("num_4", 4'd4);
        @(negedge clk);
        up = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1 push("hold_up", 4'd5);
        end
        @(negedge clk);
        up = 1'b0;
        press_dn("num_back_4", 4'd4);

        // 4 / 4
        press_ok("den_start", 4'd0);
        press_up("den_1", 4'd1);
        press_up("den_2", 4'd2);
        press_up("den_3", 4'd3);
        press_up("den_4", 4'd4);
        press_up("den_5", 4'd5);
        press_dn("den_4b", 4'd4);
        press_ok("q_4_4", 4'd1);
        press_ok("r_4_4", 4'd0);
        press_ok("back_load_num", 4'd0);
        press_up("num_cleared", 4'd1);
        press_dn("num_to_0", 4'd0);

        // 13 / 4, numerator reached by wrapping down from 0
        press_dn("wrap_dn_15", 4'd15);
        press_dn("num_14", 4'd14);
        press_dn("num_13", 4'd13);
        press_ok("den_cleared", 4'd0);
        for (int i = 1; i <= 4; i++) press_up("den_step", 4'(i));
        press_ok("q_13_4", 4'd3);
        press_ok("r_13_4", 4'd1);
        press_ok("clr_13_4", 4'd0);

        // 15 / 1
        press_dn("num_15", 4'd15);
        press_ok("den_0", 4'd0);
        press_up("den_1_15", 4'd1);
        press_ok("q_15_1", 4'd15);
        press_ok("r_15_1", 4'd0);
        press_ok("clr_15_1", 4'd0);

        // 3 / 7
        press_up("n3_1", 4'd1);
        press_up("n3_2", 4'd2);
        press_up("n3_3", 4'd3);
        press_ok("d7_0", 4'd0);
        for (int i = 1; i <= 7; i++) press_up("d7_step", 4'(i));
        press_ok("q_3_7", 4'd0);
        press_ok("r_3_7", 4'd3);
        press_ok("clr_3_7", 4'd0);

        // 9 / 0
        for (int i = 15; i >= 9; i--) press_dn("n9_step", 4'(i));
        press_ok("d0", 4'd0);
        press_ok("q_9_0", 4'd15);
        press_ok("r_9_0", 4'd9);
        press_ok("clr_9_0", 4'd0);

        // Wrap up 15 -> 0
        press_dn("wrap_pre_15", 4'd15);
        press_up("wrap_up_0", 4'd0);

        // Simultaneous inputs
        press_up("sim_num_1", 4'd1);
        pulse(1'b1, 1'b1, 1'b0, "up_dn_same", 4'd1);
        pulse(1'b1, 1'b0, 1'b1, "ok_up_same", 4'd0);
        press_up("sim_den_1", 4'd1);
        press_ok("q_sim_1_1", 4'd1);
        press_ok("r_sim_1_1", 4'd0);
        press_ok("clr_sim", 4'd0);

        // Reset in the middle of SHOW_Q
        for (int i = 1; i <= 6; i++) press_up("n6_step", 4'(i));
        press_ok("d2_0", 4'd0);
        press_up("d2_1", 4'd1);
        press_up("d2_2", 4'd2);
        press_ok("q_6_2", 4'd3);
        @(posedge clk);
        #3 rst = 1'b0;
        #1 check("reset_mid_async", leds, 4'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 push("after_mid_reset", 4'd0);
        @(negedge clk);
        press_up("post_rst_n1", 4'd1);
        press_up("post_rst_n2", 4'd2);
        press_up("post_rst_n3", 4'd3);
        press_ok("post_rst_den", 4'd0);
        press_up("post_rst_d1", 4'd1);
        press_ok("q_3_1", 4'd3);
        press_ok("r_3_1", 4'd0);
        press_ok("clr_3_1", 4'd0);

        t = 0;
        while (sb.size() > 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: pending=%0d expected 0", sb.size());
        end
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/divisor_4b.md
# divisor_4b

Interactive 4-bit unsigned divider driven by three push-button inputs (up, down, ok) with a 4-LED display. The user enters a numerator, then a denominator, by stepping a value up/down and confirming with ok. The block then shows the quotient, then the remainder. It sits directly behind the board buttons and drives the user LEDs.

## Interface
- No parameters.
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset; asynchronous, active-low (0 = reset).
- down  input  1  decrement button, active-high, synchronous to clk.
- up  input  1  increment button, active-high, synchronous to clk.
- ok  input  1  confirm/advance button, active-high, synchronous to clk.
- leds  output  4  displayed value, unsigned binary, bit 3 = MSB.

## Operation
- Edge detection:
  - Each button is registered once per clock (prev_x).
  - A press is the cycle where x=1 and prev_x=0.
  - Holding a button produces exactly one press.
  - prev_x registers reset to 0.
- State machine states: LOAD_NUM, LOAD_DEN, SHOW_Q, SHOW_R.
- Registers: num[3:0], den[3:0], quo[3:0], rem[3:0].
- Reset (rst=0, any time, including mid-sequence):
  - state=LOAD_NUM.
  - num, den, quo and rem are all set to 0.
  - leds=0.
- LOAD_NUM: leds=num.
  - up press: num=num+1, wrapping 15->0.
  - down press: num=num-1, wrapping 0->15.
  - ok press: go to LOAD_DEN.
- LOAD_DEN: leds=den. up/down act on den with the same wrap rules.
  - ok press: compute num/den and store quo and rem; go to SHOW_Q.
- SHOW_Q: leds=quo.
  - ok press: go to SHOW_R.
- SHOW_R: leds=rem.
  - ok press: clear num, den, quo and rem to 0; go to LOAD_NUM.
- up/down presses in SHOW_Q or SHOW_R are ignored.
- Simultaneous presses:
  - up and down in the same cycle: both are ignored.
  - ok together with up/down: ok wins and up/down are ignored.
- Arithmetic:
  - Unsigned 4-bit restoring division, unrolled over 4 stages, combinational.
  - Satisfies num = quo*den + rem, with rem < den.
- Divide by zero (den=0): quo=4'hF, rem=num.

## Timing
- A press sampled at rising edge N updates registers and state at that same edge N.
- leds is a combinational mux of the registered state and registers, so it is valid within edge N's clock-to-output delay.
- Division result is available in the cycle after the ok edge; there is no multi-cycle busy period.
- Every press is one action, regardless of how long the button is held.
- A new press of the same button requires at least one cycle of that input at 0 between presses.
- Reset is asynchronous: leds goes to 0 immediately on rst falling to 0, independent of clk.
- Release of reset (rst 0->1) is synchronous to clk; the first press is accepted no earlier than the first edge after release.

## Test plan
- Reset then numerator entry:
  - Stimulus: rst=0 for 1 cycle, then rst=1; four 1-cycle up pulses separated by 1 idle cycle each.
  - Required: leds=0 after reset, then leds steps 1,2,3,4.
  - Holding up high for 5 cycles adds only 1.
- Full division 4/4:
  - Stimulus: after numerator 4, ok; up×5, down×1 (leds 1,2,3,4,5,4); ok.
  - Required: leds=1 (quotient).
  - Next ok: leds=0 (remainder).
  - Next ok: leds=0 in LOAD_NUM.
- Non-trivial division 13/4:
  - Required: SHOW_Q leds=3, SHOW_R leds=1.
  - Also check 15/1 gives q=15, r=0, and 3/7 gives q=0, r=3.
- Divide by zero and wrap:
  - Stimulus: numerator 9, denominator left at 0.
  - Required: q=15, r=9.
  - In LOAD_NUM, down from 0 gives 15 and up from 15 gives 0.
- Reset mid-operation:
  - Stimulus: assert rst=0 while in SHOW_Q, asynchronously to clk.
  - Required: leds=0 immediately; after release, state is LOAD_NUM.
  - A single ok after release moves to LOAD_DEN with leds=0.
- Simultaneous inputs:
  - up and down in the same cycle in LOAD_NUM: value unchanged.
  - ok and up in the same cycle in LOAD_NUM: state advances to LOAD_DEN and num is unchanged.
